// File: rtl/sa_pkg.sv
// Shared types, defaults and arithmetic helpers for the weight-stationary systolic array.
package sa_pkg;

  localparam int SA_ROWS     = 4;
  localparam int SA_COLS     = 4;
  localparam int SA_DW       = 8;
  localparam int SA_AW       = 20;
  localparam int SA_SATURATE = 0;

  typedef enum logic {
    IDLE,
    PENDING
  } swap_state_e;

  // Operands are AW-bit signed values sign-extended to 64 bits; the 64-bit sum cannot overflow.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int aw);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (aw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (aw - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/sa_pe_cell.sv
// One weight-stationary MAC cell: shadow/active weight pair plus east/south pipeline registers.
module sa_pe_cell
  import sa_pkg::*;
#(
  parameter int DW       = SA_DW,
  parameter int AW       = SA_AW,
  parameter int SATURATE = SA_SATURATE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 w_load,
  input  logic                 commit,
  input  logic signed [DW-1:0] shadow_in,
  output logic signed [DW-1:0] shadow_out,
  input  logic signed [DW-1:0] west,
  input  logic signed [AW-1:0] north,
  output logic signed [DW-1:0] east,
  output logic signed [AW-1:0] south
);

  logic signed [DW-1:0]   shadow_q, shadow_d;
  logic signed [DW-1:0]   active_q, active_d;
  logic signed [DW-1:0]   east_q, east_d;
  logic signed [AW-1:0]   south_q, south_d;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW-1:0]   sum;

  assign prod     = (2*DW)'(active_q) * (2*DW)'(west);
  assign prod_ext = AW'(prod);

  if (SATURATE != 0) begin : g_sat
    assign sum = AW'(sat_add(64'(north), 64'(prod_ext), AW));
  end else begin : g_wrap
    assign sum = north + prod_ext;
  end

  always_comb begin
    shadow_d = w_load ? shadow_in : shadow_q;
    active_d = commit ? shadow_q : active_q;
    east_d   = west;
    south_d  = sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
      east_q   <= '0;
      south_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      east_q   <= east_d;
      south_q  <= south_d;
    end
  end

  assign shadow_out = shadow_q;
  assign east       = east_q;
  assign south      = south_q;

endmodule

// File: rtl/ws_systolic_array.sv
// ROWS x COLS weight-stationary systolic MAC array with internal input skew, output deskew
// and a double-buffered weight set committed through a swap handshake.
module ws_systolic_array
  import sa_pkg::*;
#(
  parameter int ROWS     = SA_ROWS,
  parameter int COLS     = SA_COLS,
  parameter int DW       = SA_DW,
  parameter int AW       = SA_AW,
  parameter int SATURATE = SA_SATURATE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 w_load,
  input  logic [COLS*DW-1:0]   w_in,
  input  logic                 w_swap,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ROWS*DW-1:0]   a_in,
  output logic                 out_valid,
  output logic [COLS*AW-1:0]   out_data
);

  localparam int LAT = ROWS + COLS - 1;
  localparam int CW  = $clog2(LAT + 1);

  swap_state_e          state_q, state_d;
  logic                 accept;
  logic                 commit;
  logic [LAT-1:0]       vld_q, vld_d;
  logic [CW-1:0]        inflight_q, inflight_d;
  logic signed [DW-1:0] a_row [ROWS];
  logic signed [DW-1:0] act_e [ROWS][COLS];
  logic signed [AW-1:0] psum  [ROWS][COLS];
  logic signed [DW-1:0] shd   [ROWS][COLS];

  assign a_ready   = (state_q == IDLE);
  assign accept    = a_valid & a_ready;
  assign out_valid = vld_q[LAT-1];

  // Bubbles enter as zero activations so partial sums stay clean between vectors.
  always_comb begin
    for (int unsigned r = 0; r < ROWS; r++) begin
      a_row[r] = accept ? $signed(a_in[r*DW +: DW]) : '0;
    end
  end

  always_comb begin
    vld_d      = {vld_q[LAT-2:0], accept};
    inflight_d = inflight_q;
    if (accept && !out_valid) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!accept && out_valid) begin
      inflight_d = inflight_q - CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    if (state_q == IDLE) begin
      if (w_swap) begin
        if ((inflight_q == '0) && !accept) begin
          commit = 1'b1;
        end else begin
          state_d = PENDING;
        end
      end
    end else begin
      if (inflight_q == '0) begin
        commit  = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      vld_q      <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic signed [DW-1:0] west0;

    if (r == 0) begin : g_noskew
      assign west0 = a_row[0];
    end else begin : g_skew
      logic signed [DW-1:0] skew_q [r];
      logic signed [DW-1:0] skew_d [r];

      always_comb begin
        skew_d[0] = a_row[r];
        for (int unsigned k = 1; k < r; k++) begin
          skew_d[k] = skew_q[k-1];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int unsigned k = 0; k < r; k++) begin
            skew_q[k] <= '0;
          end
        end else begin
          skew_q <= skew_d;
        end
      end

      assign west0 = skew_q[r-1];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [DW-1:0] west;
      logic signed [AW-1:0] north;
      logic signed [DW-1:0] shadow_in;

      if (c == 0) begin : g_w0
        assign west = west0;
      end else begin : g_wn
        assign west = act_e[r][c-1];
      end

      if (r == 0) begin : g_top
        assign north     = '0;
        assign shadow_in = $signed(w_in[c*DW +: DW]);
      end else begin : g_inner
        assign north     = psum[r-1][c];
        assign shadow_in = shd[r-1][c];
      end

      sa_pe_cell #(
        .DW       (DW),
        .AW       (AW),
        .SATURATE (SATURATE)
      ) u_cell (
        .clk        (clk),
        .reset      (reset),
        .w_load     (w_load),
        .commit     (commit),
        .shadow_in  (shadow_in),
        .shadow_out (shd[r][c]),
        .west       (west),
        .north      (north),
        .east       (act_e[r][c]),
        .south      (psum[r][c])
      );
    end
  end

  // Column c leaves the bottom row c cycles late; pad the rest so all columns align.
  for (genvar c = 0; c < COLS; c++) begin : g_out
    localparam int D = COLS - 1 - c;

    if (D == 0) begin : g_direct
      assign out_data[c*AW +: AW] = psum[ROWS-1][c];
    end else begin : g_dsk
      logic signed [AW-1:0] dsk_q [D];
      logic signed [AW-1:0] dsk_d [D];

      always_comb begin
        dsk_d[0] = psum[ROWS-1][c];
        for (int unsigned k = 1; k < D; k++) begin
          dsk_d[k] = dsk_q[k-1];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int unsigned k = 0; k < D; k++) begin
            dsk_q[k] <= '0;
          end
        end else begin
          dsk_q <= dsk_d;
        end
      end

      assign out_data[c*AW +: AW] = dsk_q[D-1];
    end
  end

endmodule

// File: tb/tb_ws_systolic_array.sv
// Directed bench for ws_systolic_array: table of single-vector cases plus streaming, swap and reset sequences.
module tb_ws_systolic_array;

  localparam int R   = 4;
  localparam int C   = 4;
  localparam int DW  = 8;
  localparam int AW  = 20;
  localparam int AWS = 16;

  logic clk = 1'b0;
  logic reset, w_load, w_swap, a_valid;
  logic [C*DW-1:0]  w_in;
  logic [R*DW-1:0]  a_in;
  logic a_ready, out_valid, a_ready_s, out_valid_s, a_ready_w, out_valid_w;
  logic [C*AW-1:0]  out_data;
  logic [C*AWS-1:0] out_data_s, out_data_w;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ws_systolic_array #(.ROWS(R), .COLS(C), .DW(DW), .AW(AW), .SATURATE(0)) dut (
    .clk(clk), .reset(reset), .w_load(w_load), .w_in(w_in), .w_swap(w_swap),
    .a_valid(a_valid), .a_ready(a_ready), .a_in(a_in),
    .out_valid(out_valid), .out_data(out_data));

  ws_systolic_array #(.ROWS(R), .COLS(C), .DW(DW), .AW(AWS), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .w_load(w_load), .w_in(w_in), .w_swap(w_swap),
    .a_valid(a_valid), .a_ready(a_ready_s), .a_in(a_in),
    .out_valid(out_valid_s), .out_data(out_data_s));

  ws_systolic_array #(.ROWS(R), .COLS(C), .DW(DW), .AW(AWS), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .w_load(w_load), .w_in(w_in), .w_swap(w_swap),
    .a_valid(a_valid), .a_ready(a_ready_w), .a_in(a_in),
    .out_valid(out_valid_w), .out_data(out_data_w));

  typedef struct packed {
    logic [2:0]       kind;
    logic [3:0][7:0]  a;
    logic [3:0][31:0] em;
    logic             ovf;
    logic [31:0]      es;
    logic [31:0]      ew;
  } vec_t;

  vec_t tbl [6];
  int   ntbl = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int col_m(input int c);
    return $signed(out_data[c*AW +: AW]);
  endfunction

  function automatic int col_s(input int c);
    return $signed(out_data_s[c*AWS +: AWS]);
  endfunction

  function automatic int col_w(input int c);
    return $signed(out_data_w[c*AWS +: AWS]);
  endfunction

  // 0 identity, 1 ones, 2 minus one, 3 max positive, 4 column index+1, 5 ramp r*4+c, 6 doubled identity
  function automatic logic [7:0] wgt(input int kind, input int r, input int c);
    int v;
    case (kind)
      0:       v = (r == c) ? 1 : 0;
      1:       v = 1;
      2:       v = -1;
      3:       v = 127;
      4:       v = c + 1;
      5:       v = r * 4 + c;
      default: v = (r == c) ? 2 : 0;
    endcase
    return v[7:0];
  endfunction

  task automatic set_w_row(input int kind, input int r);
    for (int c = 0; c < C; c++) w_in[c*DW +: DW] = wgt(kind, r, c);
  endtask

  task automatic load_weights(input int kind);
    for (int i = 0; i < R; i++) begin
      w_load = 1'b1;
      set_w_row(kind, R - 1 - i);
      tick;
    end
    w_load = 1'b0;
  endtask

  task automatic swap_now;
    w_swap = 1'b1;
    tick;
    w_swap = 1'b0;
  endtask

  task automatic add(input int kind, input int a0, input int a1, input int a2, input int a3,
                     input int m0, input int m1, input int m2, input int m3,
                     input bit ovf, input int es, input int ew);
    tbl[ntbl].kind  = kind[2:0];
    tbl[ntbl].a[0]  = a0[7:0];
    tbl[ntbl].a[1]  = a1[7:0];
    tbl[ntbl].a[2]  = a2[7:0];
    tbl[ntbl].a[3]  = a3[7:0];
    tbl[ntbl].em[0] = m0;
    tbl[ntbl].em[1] = m1;
    tbl[ntbl].em[2] = m2;
    tbl[ntbl].em[3] = m3;
    tbl[ntbl].ovf   = ovf;
    tbl[ntbl].es    = es;
    tbl[ntbl].ew    = ew;
    ntbl++;
  endtask

  initial begin
    int q[$];
    int k, e, exp, old_pushed, popped;
    bit new_phase;
    logic [7:0] kb;

    add(0,    1,    2,    3,    4,     1,   2,   3,   4,  1'b0,     0,     0);
    add(1,    1,    2,    3,    4,    10,  10,  10,  10,  1'b0,     0,     0);
    add(2, -128, -128, -128, -128,   512, 512, 512, 512,  1'b0,     0,     0);
    add(3,  127,  127,  127,  127, 64516,64516,64516,64516, 1'b1, 32767, -1020);
    add(4,    1,    1,    1,    1,     4,   8,  12,  16,  1'b0,     0,     0);
    add(5,    1,   -1,    2,   -2,   -12, -12, -12, -12,  1'b0,     0,     0);

    reset = 1'b1; w_load = 1'b0; w_swap = 1'b0; a_valid = 1'b0; w_in = '0; a_in = '0;
    tick;
    tick;
    reset = 1'b0;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", (out_data == '0) ? 1 : 0, 1);
    chk("reset a_ready", a_ready, 1);

    for (int i = 0; i < ntbl; i++) begin
      load_weights(tbl[i].kind);
      swap_now;
      chk($sformatf("vec%0d a_ready", i), a_ready, 1);
      a_valid = 1'b1;
      a_in    = tbl[i].a;
      tick;
      a_valid = 1'b0;
      a_in    = '0;
      repeat (5) tick;
      chk($sformatf("vec%0d early valid", i), out_valid, 0);
      tick;
      chk($sformatf("vec%0d valid", i), out_valid, 1);
      chk($sformatf("vec%0d sat valid", i), out_valid_s, 1);
      for (int c = 0; c < C; c++) begin
        exp = tbl[i].em[c];
        chk($sformatf("vec%0d col%0d", i, c), col_m(c), exp);
        if (tbl[i].ovf) exp = tbl[i].es;
        chk($sformatf("vec%0d sat16 col%0d", i, c), col_s(c), exp);
        if (tbl[i].ovf) exp = tbl[i].ew;
        else            exp = tbl[i].em[c];
        chk($sformatf("vec%0d wrap16 col%0d", i, c), col_w(c), exp);
      end
      tick;
      chk($sformatf("vec%0d valid drops", i), out_valid, 0);
    end

    // Back-to-back stream of 8 vectors through all-ones weights.
    load_weights(1);
    swap_now;
    for (int j = 0; j < 20; j++) begin
      k       = j + 1;
      kb      = k[7:0];
      a_valid = (j < 8);
      a_in    = {kb, kb, kb, kb};
      tick;
      chk($sformatf("b2b valid j%0d", j), out_valid, (j >= 6 && j < 14) ? 1 : 0);
      if (j >= 6 && j < 14) begin
        for (int c = 0; c < C; c++) chk($sformatf("b2b j%0d col%0d", j, c), col_m(c), 4 * (j - 5));
      end
    end
    a_valid = 1'b0;

    // Swap while streaming: shift in 2*I behind the all-ones set, then request a commit.
    k = 1; old_pushed = 0; popped = 0; new_phase = 1'b0;
    for (int j = 0; j < 50; j++) begin
      kb      = k[7:0];
      a_valid = (j < 30);
      a_in    = {kb, kb, kb, kb};
      w_load  = (j >= 3 && j <= 6);
      if (j >= 3 && j <= 6) set_w_row(6, 6 - j);
      w_swap  = (j == 7);
      if (j == 8) chk("swap pending a_ready", a_ready, 0);
      if (j > 7 && !new_phase && a_ready) begin
        new_phase = 1'b1;
        chk("swap old drained before ready", old_pushed - popped, 0);
      end
      if (a_valid && a_ready) begin
        if (new_phase) q.push_back(2 * k);
        else begin
          q.push_back(4 * k);
          old_pushed++;
        end
        k++;
      end
      tick;
      if (out_valid) begin
        if (q.size() == 0) chk("swap unexpected output", q.size(), 1);
        else begin
          e = q.pop_front();
          popped++;
          for (int c = 0; c < C; c++) chk($sformatf("swap out%0d col%0d", popped, c), col_m(c), e);
        end
      end
    end
    w_load = 1'b0; w_swap = 1'b0; a_valid = 1'b0;
    chk("swap all emerged", q.size(), 0);
    chk("swap ready returned", new_phase, 1);
    chk("swap new-weight outputs", (popped > old_pushed) ? 1 : 0, 1);

    // Reset with three vectors in flight; cleared weights must then yield zeros.
    a_in = {8'd4, 8'd3, 8'd2, 8'd1};
    for (int j = 0; j < 3; j++) begin
      a_valid = 1'b1;
      tick;
    end
    a_valid = 1'b0;
    reset   = 1'b1;
    tick;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset out_data", (out_data == '0) ? 1 : 0, 1);
    chk("midreset a_ready", a_ready, 1);
    reset   = 1'b0;
    a_valid = 1'b1;
    tick;
    a_valid = 1'b0;
    chk("postreset stale valid s0", out_valid, 0);
    for (int s = 1; s < 6; s++) begin
      tick;
      chk($sformatf("postreset stale valid s%0d", s), out_valid, 0);
    end
    tick;
    chk("postreset valid", out_valid, 1);
    for (int c = 0; c < C; c++) chk($sformatf("postreset col%0d", c), col_m(c), 0);
    tick;
    chk("postreset valid drops", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
